// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the Kyber NTT memory controller slice.
package ntt_pkg;
  localparam int N          = 256;
  localparam int AW         = 8;
  localparam int DW         = 12;
  localparam int Q          = 3329;
  localparam int NUM_STAGES = 7;
  localparam int ZW         = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/ntt_mem_ctrl_if.sv
// Control/address bundle between the polynomial FSM, the NTT controller and the RAM/butterfly.
// NTT_MEM_CTRL_INTT_EN adds the inv request bit sampled with start.
interface ntt_mem_ctrl_if;
  import ntt_pkg::*;

  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic          we_a;
  logic          we_b;
  logic          bf_in_valid;
  logic [ZW-1:0] zeta_idx;
`ifdef NTT_MEM_CTRL_INTT_EN
  logic          inv;

  modport master (input start, input inv, output busy, output done, output addr_a, output addr_b,
                  output we_a, output we_b, output bf_in_valid, output zeta_idx);
  modport slave  (output start, output inv, input busy, input done, input addr_a, input addr_b,
                  input we_a, input we_b, input bf_in_valid, input zeta_idx);
`else
  modport master (input start, output busy, output done, output addr_a, output addr_b,
                  output we_a, output we_b, output bf_in_valid, output zeta_idx);
  modport slave  (output start, input busy, input done, input addr_a, input addr_b,
                  input we_a, input we_b, input bf_in_valid, input zeta_idx);
`endif
endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational (stage, butterfly j) -> operand addresses and twiddle index, forward or inverse.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [2:0]    stage,
  input  logic [6:0]    j,
  input  logic          inv,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [ZW-1:0] zeta_idx
);
  logic [AW-1:0] len;
  logic [AW-1:0] mask;
  logic [AW-1:0] jj;
  logic [AW-1:0] grp;

  always_comb begin
    len  = inv ? (AW'(2) << stage) : (AW'(128) >> stage);
    mask = len - AW'(1);
    jj   = {1'b0, j};
    // Inserting a zero at bit log2(len) of j gives 2*len*grp + off.
    addr_a = ((jj & ~mask) << 1) | (jj & mask);
    addr_b = addr_a | len;
    grp    = inv ? (jj >> (stage + 3'd1)) : (jj >> (3'd7 - stage));
    // Inverse walks zetas 127 downward group-major; groups before stage s total 128-(128>>s).
    zeta_idx = inv ? ZW'((AW'(128) >> stage) - AW'(1) - grp)
                   : ZW'((AW'(1) << stage) + grp);
  end
endmodule

// File: rtl/ntt_mem_ctrl.sv
// In-place NTT sequencer for a 256x12 dual-port RAM and an external BF_LAT-deep butterfly.
// Optional inverse transform enabled by NTT_MEM_CTRL_INTT_EN.
module ntt_mem_ctrl
  import ntt_pkg::*;
#(
  parameter int N      = ntt_pkg::N,
  parameter int AW     = ntt_pkg::AW,
  parameter int BF_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ntt_mem_ctrl_if.master bus
);
  localparam int P  = N + BF_LAT;
  localparam int CW = $clog2(P);

  if ((BF_LAT % 2) != 0 || BF_LAT < 2) begin : g_bad_lat
    $error("ntt_mem_ctrl: BF_LAT must be even and at least 2");
  end
  if (AW != $clog2(N) || AW != ntt_pkg::AW) begin : g_bad_aw
    $error("ntt_mem_ctrl: AW must equal log2(N)");
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    stage, stage_n;
  logic          inv_q, inv_n, start_inv;

  logic          busy_q, done_q, we_q, bfv_q;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic [ZW-1:0] zeta_q;

  logic          rd_n, bfv_n, we_n;
  logic [AW-1:0] addr_a_n, addr_b_n, ga, gb;
  logic [ZW-1:0] zeta_n, gz;

  logic [BF_LAT:0] dl_vld;
  logic [AW-1:0]   dl_a [BF_LAT+1];
  logic [AW-1:0]   dl_b [BF_LAT+1];

`ifdef NTT_MEM_CTRL_INTT_EN
  assign start_inv = bus.inv;
`else
  assign start_inv = 1'b0;
`endif

  // state/cnt label the cycle currently on the outputs; outputs register f(next state).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stage_n = stage;
    inv_n   = inv_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ISSUE;
          cnt_n   = '0;
          stage_n = '0;
          inv_n   = start_inv;
        end
      end
      ISSUE: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(N - 2)) state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt == CW'(P - 1)) begin
          cnt_n = '0;
          if (stage == 3'(NUM_STAGES - 1)) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stage_n = stage + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  ntt_addr_gen u_addr_gen (
    .stage    (stage_n),
    .j        (cnt_n[7:1]),
    .inv      (inv_n),
    .addr_a   (ga),
    .addr_b   (gb),
    .zeta_idx (gz)
  );

  // Reads on even slots, writes come out of the delay line on odd slots.
  always_comb begin
    rd_n     = (state_n == ISSUE) && !cnt_n[0];
    bfv_n    = (state_n == ISSUE || state_n == DRAIN) && cnt_n[0] && (cnt_n < CW'(N));
    zeta_n   = bfv_n ? gz : zeta_q;
    addr_a_n = addr_a_q;
    addr_b_n = addr_b_q;
    we_n     = 1'b0;
    if (rd_n) begin
      addr_a_n = ga;
      addr_b_n = gb;
    end else if (dl_vld[BF_LAT]) begin
      addr_a_n = dl_a[BF_LAT];
      addr_b_n = dl_b[BF_LAT];
      we_n     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      stage    <= '0;
      inv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      bfv_q    <= 1'b0;
      zeta_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      dl_vld   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      stage    <= stage_n;
      inv_q    <= inv_n;
      busy_q   <= (state_n == ISSUE) || (state_n == DRAIN);
      done_q   <= (state_n == DONE);
      we_q     <= we_n;
      bfv_q    <= bfv_n;
      zeta_q   <= zeta_n;
      addr_a_q <= addr_a_n;
      addr_b_q <= addr_b_n;
      dl_vld   <= {dl_vld[BF_LAT-1:0], rd_n};
    end
  end

  // Write-back address payload; qualified by dl_vld so it needs no reset.
  always_ff @(posedge clk) begin
    dl_a[0] <= ga;
    dl_b[0] <= gb;
    for (int i = 1; i <= BF_LAT; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_b[i] <= dl_b[i-1];
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.addr_a      = addr_a_q;
  assign bus.addr_b      = addr_b_q;
  assign bus.we_a        = we_q;
  assign bus.we_b        = we_q;
  assign bus.bf_in_valid = bfv_q;
  assign bus.zeta_idx    = zeta_q;
endmodule

// File: tb/tb_ntt_mem_ctrl.sv
// Directed bench: address/timing spot checks plus full NTT through a RAM and butterfly model.
module tb_ntt_mem_ctrl;
  import ntt_pkg::*;

  localparam int BF_LAT = 4;
  localparam int P      = 256 + BF_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_mem_ctrl_if bus ();
  ntt_mem_ctrl #(.BF_LAT(BF_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc, done_cnt, done_cyc, we_bad;

  logic [11:0] mem [256];
  logic [11:0] q_a, q_b;
  logic [11:0] u_p [BF_LAT];
  logic [11:0] v_p [BF_LAT];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [11:0] ld_data;
  int          zetas [128];
  int          ref_r [256];

  function automatic int mulq(int a, int b);
    return (a * b) % 3329;
  endfunction

  function automatic int brv7(int k);
    int r = 0;
    for (int i = 0; i < 7; i++) if (k[i]) r |= (1 << (6 - i));
    return r;
  endfunction

  function automatic int pow17(int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = mulq(r, 17);
    return r;
  endfunction

  // RAM with registered reads, and a BF_LAT-deep Cooley-Tukey butterfly.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else begin
      if (bus.we_a) mem[bus.addr_a] <= u_p[BF_LAT-1];
      if (bus.we_b) mem[bus.addr_b] <= v_p[BF_LAT-1];
    end
    q_a <= mem[bus.addr_a];
    q_b <= mem[bus.addr_b];
    u_p[0] <= 12'((int'(q_a) + mulq(zetas[bus.zeta_idx], int'(q_b))) % 3329);
    v_p[0] <= 12'((int'(q_a) - mulq(zetas[bus.zeta_idx], int'(q_b)) + 3329) % 3329);
    for (int i = 1; i < BF_LAT; i++) begin
      u_p[i] <= u_p[i-1];
      v_p[i] <= v_p[i-1];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (bus.done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
    end
    if (bus.we_a !== bus.we_b) we_bad++;
    if (bus.we_a && ((cyc % P) % 2 == 0)) we_bad++;
    if (bus.we_a && !bus.busy) we_bad++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic ref_ntt();
    int k = 1;
    int t, z;
    for (int len = 128; len >= 2; len >>= 1)
      for (int st = 0; st < 256; st += 2 * len) begin
        z = zetas[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = mulq(z, ref_r[j+len]);
          ref_r[j+len] = (ref_r[j] - t + 3329) % 3329;
          ref_r[j]     = (ref_r[j] + t) % 3329;
        end
      end
  endtask

  task automatic load_rand();
    for (int i = 0; i < 256; i++) begin
      ref_r[i] = $urandom_range(0, 3328);
      ld_en    = 1'b1;
      ld_addr  = 8'(i);
      ld_data  = 12'(ref_r[i]);
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    ref_ntt();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc      = 0;
    done_cnt = 0;
    done_cyc = -1;
    we_bad   = 0;
    mon();
  endtask

  task automatic chk_result(input string tag);
    int errs = 0;
    for (int i = 0; i < 256; i++) if (int'(mem[i]) != ref_r[i]) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef NTT_MEM_CTRL_INTT_EN
    bus.inv = 1'b0;
`endif
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int k = 0; k < 128; k++) zetas[k] = pow17(brv7(k));
    cyc = 0; done_cnt = 0; done_cyc = -1; we_bad = 0;

    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_addr_a", int'(bus.addr_a), 0);
    chk("rst_addr_b", int'(bus.addr_b), 0);
    chk("rst_we_a", int'(bus.we_a), 0);
    chk("rst_we_b", int'(bus.we_b), 0);
    chk("rst_bfv", int'(bus.bf_in_valid), 0);
    chk("rst_zeta", int'(bus.zeta_idx), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1: full forward transform with spot checks.
    load_rand();
    do_start();
    chk("c0_addr_a", int'(bus.addr_a), 0);
    chk("c0_addr_b", int'(bus.addr_b), 128);
    chk("c0_we", int'(bus.we_a), 0);
    chk("c0_busy", int'(bus.busy), 1);
    tick();
    chk("c1_bfv", int'(bus.bf_in_valid), 1);
    chk("c1_zeta", int'(bus.zeta_idx), 1);
    wait_cyc(5);
    chk("c5_we_a", int'(bus.we_a), 1);
    chk("c5_we_b", int'(bus.we_b), 1);
    chk("c5_addr_a", int'(bus.addr_a), 0);
    chk("c5_addr_b", int'(bus.addr_b), 128);
    wait_cyc(10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_cyc(254);
    chk("s0j127_a", int'(bus.addr_a), 127);
    chk("s0j127_b", int'(bus.addr_b), 255);
    wait_cyc(259);
    chk("s0_lastwr_we", int'(bus.we_a), 1);
    chk("s0_lastwr_a", int'(bus.addr_a), 127);
    wait_cyc(260);
    chk("s1_first_we", int'(bus.we_a), 0);
    chk("s1_first_b", int'(bus.addr_b), 64);
    wait_cyc(388);
    chk("s1j64_a", int'(bus.addr_a), 128);
    chk("s1j64_b", int'(bus.addr_b), 192);
    tick();
    chk("s1j64_zeta", int'(bus.zeta_idx), 3);
    wait_cyc(1560);
    chk("s6j0_a", int'(bus.addr_a), 0);
    chk("s6j0_b", int'(bus.addr_b), 2);
    tick();
    chk("s6j0_zeta", int'(bus.zeta_idx), 64);
    wait_cyc(1564);
    chk("s6j2_a", int'(bus.addr_a), 4);
    chk("s6j2_b", int'(bus.addr_b), 6);
    tick();
    chk("s6j2_zeta", int'(bus.zeta_idx), 65);
    wait_cyc(1814);
    chk("s6j127_a", int'(bus.addr_a), 253);
    chk("s6j127_b", int'(bus.addr_b), 255);
    tick();
    chk("s6j127_zeta", int'(bus.zeta_idx), 127);
    wait_cyc(1819);
    chk("c1819_busy", int'(bus.busy), 1);
    chk("c1819_done", int'(bus.done), 0);
    tick();
    chk("c1820_done", int'(bus.done), 1);
    chk("c1820_busy", int'(bus.busy), 0);
    tick();
    chk("c1821_done", int'(bus.done), 0);
    chk("run1_done_cnt", done_cnt, 1);
    chk("run1_done_cyc", done_cyc, 1820);
    chk("run1_we_slots", we_bad, 0);
    chk_result("run1_ntt");

    // Run 2: asynchronous reset in the middle, then a clean rerun.
    load_rand();
    do_start();
    wait_cyc(701);
    chk("c701_we", int'(bus.we_a), 1);
    chk("c701_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we_a", int'(bus.we_a), 0);
    chk("arst_we_b", int'(bus.we_b), 0);
    chk("arst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_rand();
    do_start();
    wait_cyc(1825);
    chk("run2_done_cnt", done_cnt, 1);
    chk("run2_done_cyc", done_cyc, 1820);
    chk("run2_we_slots", we_bad, 0);
    chk_result("run2_ntt");

`ifdef NTT_MEM_CTRL_INTT_EN
    bus.inv = 1'b1;
    do_start();
    bus.inv = 1'b0;
    chk("inv_s0j0_a", int'(bus.addr_a), 0);
    chk("inv_s0j0_b", int'(bus.addr_b), 2);
    tick();
    chk("inv_s0j0_zeta", int'(bus.zeta_idx), 127);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_mem_ctrl.md
Name: ntt_mem_ctrl

Overview:
- Initiator-side controller that drives both ports of the 256x12 true dual-port coefficient RAM through a full in-place Kyber forward NTT: 7 stages of 128 Cooley-Tukey butterflies each.
- Sequences the RAM addresses and write enables, tells the external butterfly unit when its operands are valid, supplies the twiddle (zeta) index, and schedules the write-back of the butterfly results.
- Sits between the top-level polynomial multiplier FSM (start/done) and the RAM plus butterfly datapath. Data never passes through this block: RAM q_a/q_b feed the butterfly directly, and the butterfly u/v outputs drive RAM data_a/data_b directly.

Parameters:
- N, 256: coefficients per polynomial.
- AW, 8: RAM address width, log2(N).
- BF_LAT, 4: butterfly pipeline latency in cycles, from bf_in_valid to result valid. Must be even; otherwise elaboration-time error.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to run one NTT; ignored unless in IDLE.
- busy, output, 1: high while a transform is in progress.
- done, output, 1: one-cycle pulse when the transform completes.
- addr_a, output, AW: RAM port A address (read or write).
- addr_b, output, AW: RAM port B address.
- we_a, output, 1: RAM port A write enable.
- we_b, output, 1: RAM port B write enable.
- bf_in_valid, output, 1: RAM q_a/q_b hold a butterfly operand pair this cycle.
- zeta_idx, output, 7: twiddle ROM index, aligned with bf_in_valid.

Behaviour:
- All outputs registered. Reset values: busy=0, done=0, addr_a=0, addr_b=0, we_a=0, we_b=0, bf_in_valid=0, zeta_idx=0.
- States and transitions:
  - IDLE -> ISSUE when start=1.
  - ISSUE -> DRAIN after the last read of a stage.
  - DRAIN -> ISSUE for the next stage once the stage's last write has been issued.
  - DRAIN -> DONE after stage 6.
  - DONE -> IDLE after one cycle; done=1 only while in DONE.
- Stage s in 0..6:
  - len = 128>>s.
  - For butterfly j in 0..127: grp = j/len, off = j%len.
  - Read addresses: addr_a = 2*len*grp + off, addr_b = addr_a + len.
  - zeta_idx = 2^s + grp.
- Timing, relative to stage cycle 0 (first read of the stage):
  - Reads are issued on even slots o = 2j, with we=0.
  - bf_in_valid=1 and zeta_idx are driven at o+1.
  - The write of the same addr pair, with we_a=we_b=1, is driven at o+1+BF_LAT. This always falls on an odd slot, so ports never carry a read and a write in the same cycle.
  - Write addresses are held in an internal delay line of depth BF_LAT+1.
  - Stage period P = 256+BF_LAT: the last write is at 255+BF_LAT, and the next stage's first read is at P.
  - Draining before the next stage guarantees stage s+1 only reads values already written by stage s.
- Overall timing:
  - start sampled at an edge makes the following cycle stage 0 cycle 0.
  - busy is high for cycles 0..7P-1.
  - done pulses at cycle 7P; with BF_LAT=4, 1820 cycles after the first read.
- Idle cycles (neither read nor write) keep we low and hold the previous addresses.
- start while busy or in DONE: ignored, with no restart or queueing.
- Async reset mid-transform: returns to IDLE immediately and we drops. RAM contents are then undefined with respect to the transform, and the next start reruns from stage 0.

Optional Feature:
- Macro NTT_MEM_CTRL_INTT_EN adds input port inv (1 bit), sampled with start.
- inv=1 runs the Gentleman-Sande inverse:
  - Stages s=0..6 with len = 2<<s.
  - Same address formulas.
  - zeta_idx starts at 127 and decrements once per group across the whole transform (group-major order).
- inv=0, or macro absent: forward NTT only. Without the macro, inv does not exist.

Decomposition:
- Shared package ntt_pkg: N, AW, DW=12, Q=3329, NUM_STAGES=7, ZW=7, state enum typedef.
- One natural sub-module, ntt_addr_gen: combinational (stage, j) -> (addr_a, addr_b, zeta_idx). It is reusable by the pointwise-multiply controller.

Test Plan:
- start after reset, stage 0: cycle 0 gives addr 0/128, we=0; cycle 1 gives bf_in_valid=1, zeta_idx=1; cycle 5 gives addr 0/128, we_a=we_b=1. j=127 reads 127/255.
- Stage 1, j=64: read 128/192, zeta_idx=3. Its first read is at cycle 260, strictly after the stage-0 last write at cycle 259.
- Stage 6, j=0 -> 0/2, zeta 64; j=2 -> 4/6, zeta 65; j=127 -> 253/255, zeta 127.
- Full run with a behavioural RAM and a BF_LAT=4 golden Kyber butterfly model: output equals the reference NTT of a random polynomial. done is a single pulse at cycle 1820, and no cycle has read/write port overlap.
- start pulses during busy are ignored. Deasserting rst_n at cycle 700 forces we=0 and busy=0 asynchronously. A following start reruns the full 1820-cycle transform.
- With NTT_MEM_CTRL_INTT_EN and inv=1: stage 0 j=0 reads 0/2 with zeta_idx=127. The forward-then-inverse round trip reproduces the input scaled per the inverse definition.
